prod_acc: RTL and testbench

Frame accumulator that sits directly downstream of the 16x16 multiplier stage. It takes the 32-bit unsigned product stream over a valid/ready handshake and sums FRAME_LEN products, or fewer when a flush closes the frame early. It emits one ACC_W-bit sum per frame with a beat count and an overflow flag, and holds that result in a single-entry output register until the consumer accepts it.

---
 rtl/prod_acc_pkg.sv | 16 +
 rtl/prod_acc_add.sv | 37 +++
 rtl/prod_acc.sv | 146 ++++++++++++++
 tb/tb_prod_acc.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prod_acc_pkg.sv
// prod_acc_pkg
//   Shared constants and types for the product frame accumulator.
//   PROD_W : width of the unsigned product coming from the 16x16 multiplier.
//   CNT_W  : width of the per-frame beat counter and of out_count.
//   buf_state_t : state of the single-entry output buffer.
package prod_acc_pkg;

  localparam int PROD_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/prod_acc_add.sv
// prod_acc_add
//   ACC_W-bit accumulator adder: acc + zero-extended 32-bit product, with
//   the carry out of ACC_W reported separately.
//   Build option PROD_ACC_SAT_EN: when defined, a carry out clamps the sum
//   to all ones instead of wrapping modulo 2^ACC_W.
// Ports
//   acc   in   ACC_W   current running sum
//   prod  in   PROD_W  unsigned product to add
//   sum   out  ACC_W   wrapped or clamped result
//   carry out  1       the true sum did not fit in ACC_W bits
module prod_acc_add
  import prod_acc_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  // One extra bit on top captures the carry; ACC_W >= PROD_W so the pad
  // width is always at least one.
  logic [ACC_W:0] raw_sum;

  assign raw_sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
  assign carry   = raw_sum[ACC_W];

`ifdef PROD_ACC_SAT_EN
  // Products are unsigned, so once clamped every later carry clamps again
  // and the value stays pinned at the maximum for the rest of the frame.
  assign sum = carry ? {ACC_W{1'b1}} : raw_sum[ACC_W-1:0];
`else
  assign sum = raw_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/prod_acc.sv
// prod_acc
//   Frame accumulator behind the multiplier stage. Sums FRAME_LEN accepted
//   products (or fewer when a flush closes the frame early) and presents one
//   result per frame in a single-entry output register.
//   Build option PROD_ACC_SAT_EN (in prod_acc_add): saturate instead of wrap.
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_prod    in   32     unsigned product
//   in_valid   in   1      in_prod valid
//   in_ready   out  1      a beat can be taken this cycle
//   flush      in   1      close the open frame early
//   out_sum    out  ACC_W  frame sum
//   out_count  out  16     beats in the frame
//   out_ovf    out  1      frame overflowed ACC_W
//   out_valid  out  1      result held
//   out_ready  in   1      consumer takes the result
module prod_acc
  import prod_acc_pkg::*;
#(
  parameter int FRAME_LEN = 256,
  parameter int ACC_W     = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  buf_state_t       state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;
  logic             flush_pend_reg, flush_pend_next;
  logic [ACC_W-1:0] out_sum_reg, out_sum_next;
  logic [CNT_W-1:0] out_count_reg, out_count_next;
  logic             out_ovf_reg, out_ovf_next;

  logic             accept;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic [ACC_W-1:0] beat_sum;
  logic [CNT_W-1:0] beat_cnt;
  logic             beat_ovf;
  logic             frame_nonempty;
  logic             close_len;
  logic             close_flush;
  logic             close;

  prod_acc_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc   (acc_reg),
    .prod  (in_prod),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign out_valid = (state_reg == HELD);
  // The buffer can be refilled in the same cycle it is drained, so the
  // input never stalls while the consumer keeps out_ready high.
  assign in_ready  = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready;

  // Frame totals including this cycle's beat, if any.
  assign beat_sum       = accept ? add_sum : acc_reg;
  assign beat_cnt       = cnt_reg + {{(CNT_W - 1){1'b0}}, accept};
  assign beat_ovf       = ovf_reg | (accept & add_carry);
  assign frame_nonempty = (cnt_reg != '0) | accept;

  assign close_len   = accept & (cnt_reg == LAST_CNT);
  assign close_flush = (flush | flush_pend_reg) & in_ready & frame_nonempty;
  assign close       = close_len | close_flush;

  always_comb begin
    state_next      = state_reg;
    acc_next        = acc_reg;
    cnt_next        = cnt_reg;
    ovf_next        = ovf_reg;
    flush_pend_next = flush_pend_reg;
    out_sum_next    = out_sum_reg;
    out_count_next  = out_count_reg;
    out_ovf_next    = out_ovf_reg;

    if (close) begin
      // A close always loads the buffer; any held result is being consumed
      // this cycle because close requires in_ready.
      out_sum_next    = beat_sum;
      out_count_next  = beat_cnt;
      out_ovf_next    = beat_ovf;
      state_next      = HELD;
      acc_next        = '0;
      cnt_next        = '0;
      ovf_next        = 1'b0;
      flush_pend_next = 1'b0;
    end else begin
      acc_next = beat_sum;
      cnt_next = beat_cnt;
      ovf_next = beat_ovf;
      // A flush that cannot close now (buffer full) is remembered; a flush
      // against an empty frame has nothing to close and is dropped.
      if (flush && frame_nonempty) begin
        flush_pend_next = 1'b1;
      end
      if (out_ready) begin
        state_next = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= EMPTY;
      acc_reg        <= '0;
      cnt_reg        <= '0;
      ovf_reg        <= 1'b0;
      flush_pend_reg <= 1'b0;
      out_sum_reg    <= '0;
      out_count_reg  <= '0;
      out_ovf_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      acc_reg        <= acc_next;
      cnt_reg        <= cnt_next;
      ovf_reg        <= ovf_next;
      flush_pend_reg <= flush_pend_next;
      out_sum_reg    <= out_sum_next;
      out_count_reg  <= out_count_next;
      out_ovf_reg    <= out_ovf_next;
    end
  end

  assign out_sum   = out_sum_reg;
  assign out_count = out_count_reg;
  assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_prod_acc.sv
// tb_prod_acc
//   Self-checking bench for prod_acc. Instance a: FRAME_LEN=4, ACC_W=40
//   (table-driven vectors, backpressure and reset sequences). Instance b:
//   FRAME_LEN=8, ACC_W=34 (overflow case and randomized traffic against a
//   frame-level reference model). Honours PROD_ACC_SAT_EN for expectations.
module tb_prod_acc;

  localparam int FL_A = 4;
  localparam int AW_A = 40;
  localparam int FL_B = 8;
  localparam int AW_B = 34;

`ifdef PROD_ACC_SAT_EN
  localparam bit SAT = 1'b1;
  localparam logic [63:0] OVF_SUM_EXP = 64'h3_FFFF_FFFF;
`else
  localparam bit SAT = 1'b0;
  localparam logic [63:0] OVF_SUM_EXP = 64'h3_FFF0_0008;
`endif

  logic clk = 1'b0;
  logic rst;

  logic [31:0]     a_in_prod, b_in_prod;
  logic            a_in_valid, b_in_valid;
  logic            a_in_ready, b_in_ready;
  logic            a_flush, b_flush;
  logic [AW_A-1:0] a_out_sum;
  logic [AW_B-1:0] b_out_sum;
  logic [15:0]     a_out_count, b_out_count;
  logic            a_out_ovf, b_out_ovf;
  logic            a_out_valid, b_out_valid;
  logic            a_out_ready, b_out_ready;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  prod_acc #(.FRAME_LEN(FL_A), .ACC_W(AW_A)) dut_a (
    .clk(clk), .rst(rst), .in_prod(a_in_prod), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .flush(a_flush), .out_sum(a_out_sum),
    .out_count(a_out_count), .out_ovf(a_out_ovf), .out_valid(a_out_valid),
    .out_ready(a_out_ready)
  );

  prod_acc #(.FRAME_LEN(FL_B), .ACC_W(AW_B)) dut_b (
    .clk(clk), .rst(rst), .in_prod(b_in_prod), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .flush(b_flush), .out_sum(b_out_sum),
    .out_count(b_out_count), .out_ovf(b_out_ovf), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] prod;
    logic        fl;
    logic        ordy;
    logic        ev;
    logic [63:0] esum;
    logic [15:0] ecnt;
    logic        eovf;
    logic        erdy;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic add_vec(input logic v, input logic [31:0] prod, input logic fl, input logic ordy,
                         input logic ev, input logic [63:0] esum, input logic [15:0] ecnt,
                         input logic eovf, input logic erdy);
    vec_t r;
    r.v = v; r.prod = prod; r.fl = fl; r.ordy = ordy;
    r.ev = ev; r.esum = esum; r.ecnt = ecnt; r.eovf = eovf; r.erdy = erdy;
    vq.push_back(r);
  endtask

  // Apply one cycle of inputs at the falling edge and settle before checks.
  task automatic drive_a(input logic v, input logic [31:0] prod, input logic fl, input logic ordy);
    @(negedge clk);
    a_in_valid = v; a_in_prod = prod; a_flush = fl; a_out_ready = ordy;
    #1;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] prod, input logic fl, input logic ordy);
    @(negedge clk);
    b_in_valid = v; b_in_prod = prod; b_flush = fl; b_out_ready = ordy;
    #1;
  endtask

  task automatic check_a_result(input string name, input logic [63:0] esum, input logic [15:0] ecnt,
                                input logic eovf);
    check({name, ".valid"}, 64'(a_out_valid), 64'd1);
    check({name, ".sum"},   64'(a_out_sum),   esum);
    check({name, ".count"}, 64'(a_out_count), 64'(ecnt));
    check({name, ".ovf"},   64'(a_out_ovf),   64'(eovf));
  endtask

  // Frame-level reference model state for instance b.
  logic [79:0] m_true_sum;
  int          m_nbeats;
  bit          m_pend;
  bit          m_held;
  logic [33:0] m_hsum;
  logic [15:0] m_hcnt;
  bit          m_hovf;

  initial begin
    logic        rv, rfl, rordy, exp_rdy, accepted, closing;
    logic [31:0] rprod;

    rst = 1'b1;
    a_in_valid = 0; a_in_prod = 0; a_flush = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_prod = 0; b_flush = 0; b_out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.in_ready",  64'(a_in_ready),  64'd1);
    check("reset.out_valid", 64'(a_out_valid), 64'd0);
    check("reset.out_sum",   64'(a_out_sum),   64'd0);
    check("reset.out_count", 64'(a_out_count), 64'd0);
    check("reset.out_ovf",   64'(a_out_ovf),   64'd0);
    check("reset_b.out_valid", 64'(b_out_valid), 64'd0);
    rst = 1'b0;

    // Full frame, early flush, flush with a beat, empty flush.
    for (int i = 0; i < 4; i++) add_vec(1, 32'hFFFE0001, 0, 1, 0, 0, 0, 0, 1);
    add_vec(0, 0,  0, 1, 1, 64'h3_FFF8_0004, 16'd4, 0, 1);
    add_vec(1, 5,  0, 1, 0, 0, 0, 0, 1);
    add_vec(1, 7,  0, 1, 0, 0, 0, 0, 1);
    add_vec(0, 0,  1, 1, 0, 0, 0, 0, 1);
    add_vec(0, 0,  0, 1, 1, 64'd12, 16'd2, 0, 1);
    add_vec(1, 1,  0, 1, 0, 0, 0, 0, 1);
    add_vec(1, 2,  0, 1, 0, 0, 0, 0, 1);
    add_vec(1, 3,  1, 1, 0, 0, 0, 0, 1);
    add_vec(0, 0,  0, 1, 1, 64'd6, 16'd3, 0, 1);
    add_vec(0, 0,  1, 1, 0, 0, 0, 0, 1);
    add_vec(0, 0,  0, 1, 0, 0, 0, 0, 1);
    add_vec(0, 0,  0, 1, 0, 0, 0, 0, 1);

    foreach (vq[i]) begin
      drive_a(vq[i].v, vq[i].prod, vq[i].fl, vq[i].ordy);
      check($sformatf("vec%0d.in_ready", i),  64'(a_in_ready),  64'(vq[i].erdy));
      check($sformatf("vec%0d.out_valid", i), 64'(a_out_valid), 64'(vq[i].ev));
      if (vq[i].ev) begin
        check($sformatf("vec%0d.out_sum", i),   64'(a_out_sum),   vq[i].esum);
        check($sformatf("vec%0d.out_count", i), 64'(a_out_count), 64'(vq[i].ecnt));
        check($sformatf("vec%0d.out_ovf", i),   64'(a_out_ovf),   64'(vq[i].eovf));
      end
      $display("vec %0d: v=%0b prod=0x%0h fl=%0b ordy=%0b -> valid=%0b sum=0x%0h cnt=%0d",
               i, vq[i].v, vq[i].prod, vq[i].fl, vq[i].ordy, a_out_valid, a_out_sum, a_out_count);
    end

    // Backpressure: frame 1 held with out_ready low; the next beat stalls
    // and the held result must not move. Releasing out_ready swaps in a
    // one-beat frame (flush with beat) without dropping out_valid.
    drive_a(1, 1, 0, 0);
    drive_a(1, 2, 0, 0);
    drive_a(1, 3, 0, 0);
    drive_a(1, 4, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive_a(1, 100, 1, 0);
      check("bp.in_ready_low", 64'(a_in_ready), 64'd0);
      check_a_result("bp.frame1_stable", 64'd10, 16'd4, 0);
    end
    drive_a(1, 100, 1, 1);
    check("bp.in_ready_up", 64'(a_in_ready), 64'd1);
    check_a_result("bp.frame1_last", 64'd10, 16'd4, 0);
    drive_a(1, 200, 1, 1);
    check_a_result("bp.swap1", 64'd100, 16'd1, 0);
    drive_a(0, 0, 0, 1);
    check_a_result("bp.swap2", 64'd200, 16'd1, 0);
    drive_a(0, 0, 0, 1);
    check("bp.drained", 64'(a_out_valid), 64'd0);
    $display("backpressure sequence done");

    // Reset during the 3rd beat of a partial frame, then four beats of 1.
    drive_a(1, 9, 0, 1);
    drive_a(1, 9, 0, 1);
    @(negedge clk);
    rst = 1'b1; a_in_valid = 1; a_in_prod = 9;
    drive_a(1, 1, 0, 1);
    rst = 1'b0;
    check("rst.out_valid", 64'(a_out_valid), 64'd0);
    check("rst.in_ready",  64'(a_in_ready),  64'd1);
    drive_a(1, 1, 0, 1);
    drive_a(1, 1, 0, 1);
    drive_a(1, 1, 0, 1);
    drive_a(0, 0, 0, 1);
    check_a_result("rst.frame", 64'd4, 16'd4, 0);
    $display("reset mid-frame sequence done: sum=%0d cnt=%0d", a_out_sum, a_out_count);

    // Overflow on the 34-bit instance.
    for (int k = 0; k < 8; k++) drive_b(1, 32'hFFFE0001, 0, 1);
    drive_b(0, 0, 0, 1);
    check("ovf.valid", 64'(b_out_valid), 64'd1);
    check("ovf.sum",   64'(b_out_sum),   OVF_SUM_EXP);
    check("ovf.count", 64'(b_out_count), 64'd8);
    check("ovf.flag",  64'(b_out_ovf),   64'd1);
    $display("overflow frame: sum=0x%0h ovf=%0b", b_out_sum, b_out_ovf);
    drive_b(0, 0, 0, 1);
    check("ovf.drained", 64'(b_out_valid), 64'd0);

    // Randomized traffic on instance b against a frame-level model.
    m_true_sum = '0; m_nbeats = 0; m_pend = 0; m_held = 0;
    m_hsum = '0; m_hcnt = '0; m_hovf = 0;
    for (int c = 0; c < 600; c++) begin
      rv    = ($urandom_range(0, 3) != 0);
      rprod = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
      rfl   = ($urandom_range(0, 9) == 0);
      rordy = ($urandom_range(0, 3) != 0);
      drive_b(rv, rprod, rfl, rordy);

      exp_rdy = !m_held || rordy;
      check("rnd.in_ready",  64'(b_in_ready),  64'(exp_rdy));
      check("rnd.out_valid", 64'(b_out_valid), 64'(m_held));
      if (m_held) begin
        check("rnd.out_sum",   64'(b_out_sum),   64'(m_hsum));
        check("rnd.out_count", 64'(b_out_count), 64'(m_hcnt));
        check("rnd.out_ovf",   64'(b_out_ovf),   64'(m_hovf));
      end

      accepted = rv && exp_rdy;
      if (accepted) begin
        m_true_sum += 80'(rprod);
        m_nbeats++;
      end
      closing = (accepted && m_nbeats == FL_B) ||
                ((rfl || m_pend) && exp_rdy && m_nbeats > 0);
      if (closing) begin
        m_held = 1;
        m_hcnt = 16'(m_nbeats);
        m_hovf = (m_true_sum >= (80'd1 << AW_B));
        m_hsum = (SAT && m_hovf) ? '1 : m_true_sum[AW_B-1:0];
        $display("rnd cycle %0d: frame closed cnt=%0d sum=0x%0h ovf=%0b", c, m_hcnt, m_hsum, m_hovf);
        m_true_sum = '0; m_nbeats = 0; m_pend = 0;
      end else begin
        if (m_held && rordy) m_held = 0;
        if (rfl && m_nbeats > 0) m_pend = 1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
